// File: rtl/pll_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_seq_pkg
// Brief    : Shared state encodings and default timing constants for the
//            clock-domain reset sequencers.
// Revision : 1.0
// ============================================================================
package pll_reset_seq_pkg;

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_QUALIFY   = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_HOLDOFF   = 3'd3;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STABLE_CYCLES  = 4096;
    localparam int DEF_GLITCH_CYCLES  = 4;
    localparam int DEF_HOLDOFF_CYCLES = 256;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_QUALIFY   = ST_QUALIFY,
        S_RUN       = ST_RUN,
        S_HOLDOFF   = ST_HOLDOFF
    } seq_state_e;

    // Bits needed to hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_seq_sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Brief    : N-stage synchroniser for an asynchronous single-bit input, with
//            asynchronous active-low clear.
// Revision : 1.0
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_seq
// Brief    : Qualifies PLL lock and sequences the video core reset; optional
//            loss counter enabled by PLL_RESET_SEQ_LOSS_COUNT_EN.
// Revision : 1.0
// ============================================================================
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int GLITCH_CYCLES  = DEF_GLITCH_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       core_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [2:0] state_dbg
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int                    c_glitch_w     = cnt_width(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0]      c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_holdoff_last = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [c_glitch_w-1:0] c_glitch_last  = c_glitch_w'(GLITCH_CYCLES - 1);

    logic                  w_lock_s;
    logic                  w_loss_event;
    seq_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [c_glitch_w-1:0] r_glitch;
    logic                  r_core_reset;
    logic                  r_ready;
    logic                  r_lock_lost;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (pll_lock),
        .q     (w_lock_s)
    );

    // Final low cycle of a sustained lock drop while running.
    assign w_loss_event = (r_state == S_RUN) && !w_lock_s && (r_glitch == c_glitch_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_WAIT_LOCK;
            r_cnt        <= '0;
            r_glitch     <= '0;
            r_core_reset <= 1'b1;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    r_cnt        <= '0;
                    r_glitch     <= '0;
                    r_core_reset <= 1'b1;
                    r_ready      <= 1'b0;
                    if (w_lock_s) begin
                        r_state <= S_QUALIFY;
                    end
                end
                S_QUALIFY: begin
                    if (!w_lock_s) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_LOCK;
                    end else if (r_cnt == c_stable_last) begin
                        r_cnt        <= '0;
                        r_glitch     <= '0;
                        r_core_reset <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_lock_s) begin
                        r_glitch <= '0;
                    end else if (w_loss_event) begin
                        r_glitch     <= '0;
                        r_cnt        <= '0;
                        r_core_reset <= 1'b1;
                        r_ready      <= 1'b0;
                        r_lock_lost  <= 1'b1;
                        r_state      <= S_HOLDOFF;
                    end else begin
                        r_glitch <= r_glitch + c_glitch_w'(1);
                    end
                end
                S_HOLDOFF: begin
                    // Lock is deliberately ignored until the holdoff expires.
                    r_core_reset <= 1'b1;
                    r_ready      <= 1'b0;
                    if (r_cnt == c_holdoff_last) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_LOCK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt        <= '0;
                    r_glitch     <= '0;
                    r_core_reset <= 1'b1;
                    r_ready      <= 1'b0;
                    r_state      <= S_WAIT_LOCK;
                end
            endcase
        end
    end

    assign core_reset = r_core_reset;
    assign ready      = r_ready;
    assign lock_lost  = r_lock_lost;
    assign state_dbg  = r_state;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] r_loss_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_loss_count <= '0;
        end else if (w_loss_event && (r_loss_count != 8'hFF)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign loss_count = r_loss_count;
`endif

endmodule

`default_nettype wire
